// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage: owns the PC, hides one-cycle imem latency, handles stall/redirect/fault
module if_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 8192
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_count
);
    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] next_pc;
    logic        redirect_ok;
    logic        next_ok;

    function automatic logic is_legal(input logic [31:0] addr);
        is_legal = (addr[1:0] == 2'b00) && (addr < IMEM_LIMIT);
    endfunction

    // imem_addr always names the word fetch_pc will hold after the edge,
    // so imem_rd_data lines up with fetch_pc in the following cycle.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        fault_addr_d = fault_addr_q;
        imem_addr    = fetch_pc_q;
        if_valid     = 1'b0;
        next_pc      = fetch_pc_q + 32'd4;
        redirect_ok  = is_legal(redirect_pc);
        next_ok      = is_legal(next_pc);

        case (state_q)
            BOOT: begin
                imem_addr  = RESET_PC;
                fetch_pc_d = RESET_PC;
                state_d    = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    if (redirect_ok) begin
                        imem_addr  = redirect_pc;
                        fetch_pc_d = redirect_pc;
                    end else begin
                        state_d      = FAULT;
                        fault_addr_d = redirect_pc;
                    end
                end else if (stall) begin
                    if_valid = 1'b1;
                end else begin
                    if_valid = 1'b1;
                    if (next_ok) begin
                        imem_addr  = next_pc;
                        fetch_pc_d = next_pc;
                    end else begin
                        state_d      = FAULT;
                        fault_addr_d = next_pc;
                    end
                end
            end
            FAULT: begin
                if (redirect_valid) begin
                    if (redirect_ok) begin
                        imem_addr  = redirect_pc;
                        fetch_pc_d = redirect_pc;
                        state_d    = RUN;
                    end else begin
                        fault_addr_d = redirect_pc;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        fetch_count_d = fetch_count_q + {31'd0, if_valid & ~stall};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BOOT;
            fetch_pc_q    <= RESET_PC;
            fault_addr_q  <= 32'd0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            fault_addr_q  <= fault_addr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign if_pc       = fetch_pc_q;
    assign if_instr    = imem_rd_data;
    assign fault       = (state_q == FAULT);
    assign fault_addr  = fault_addr_q;
    assign fetch_count = fetch_count_q;

endmodule
